// File: rtl/ebi_tx_vc_scheduler_if.sv
// ebi_tx_vc_scheduler_if: VC buffer, transmitter and credit signals between the scheduler (master) and its environment (slave)
interface ebi_tx_vc_scheduler_if #(
    parameter int CHANNEL_NUM       = 4,
    parameter int CHANNEL_NUM_WIDTH = 2
);
    logic [CHANNEL_NUM-1:0]       vc_req_valid;
    logic [CHANNEL_NUM-1:0]       vc_pop;
    logic [CHANNEL_NUM-1:0]       credit_avail;
    logic                         tx_issue_valid;
    logic                         tx_issue_ready;
    logic [CHANNEL_NUM_WIDTH-1:0] tx_issue_id;
    logic                         tx_result_valid;
    logic                         tx_result_ok;
    logic                         credit_ret_valid;
    logic [CHANNEL_NUM_WIDTH-1:0] credit_ret_id;
    logic                         busy;
    logic                         retry_err;
    logic                         credit_ovf_err;

    modport master (
        input  vc_req_valid, tx_issue_ready, tx_result_valid, tx_result_ok, credit_ret_valid, credit_ret_id,
        output vc_pop, credit_avail, tx_issue_valid, tx_issue_id, busy, retry_err, credit_ovf_err
    );

    modport slave (
        output vc_req_valid, tx_issue_ready, tx_result_valid, tx_result_ok, credit_ret_valid, credit_ret_id,
        input  vc_pop, credit_avail, tx_issue_valid, tx_issue_id, busy, retry_err, credit_ovf_err
    );
endinterface

// File: rtl/ebi_tx_vc_scheduler.sv
// ebi_tx_vc_scheduler: round-robin credit-gated VC scheduler with NACK retry; EBI_SCHED_TIMEOUT_EN adds a WAIT_RESULT watchdog
module ebi_tx_vc_scheduler #(
    parameter int CHANNEL_NUM       = 4,
    parameter int CHANNEL_NUM_WIDTH = 2,
    parameter int CREDIT_INIT       = 4,
    parameter int CREDIT_CNT_WIDTH  = 3,
    parameter int MAX_RETRY         = 3,
    parameter int TIMEOUT_CYCLES    = 1024
) (
    input logic                  if_clk,
    input logic                  rst,
    ebi_tx_vc_scheduler_if.master bus
);
    localparam int NW = CHANNEL_NUM_WIDTH;
    localparam int CW = CREDIT_CNT_WIDTH;
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESULT} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          credit [CHANNEL_NUM];
    logic [CHANNEL_NUM-1:0] elig, ovf_hit;
    logic [NW-1:0]          gnt_id, rr_ptr, pick, arb_idx;
    logic [RW-1:0]          retry_cnt;
    logic                   ack, nack, drop, done, timeout;
    logic                   retry_err, credit_ovf_err;

`ifdef EBI_SCHED_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES);
    logic [WW-1:0] wd_cnt;
    assign timeout = state == WAIT_RESULT && !bus.tx_result_valid && wd_cnt == WW'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge if_clk)
        wd_cnt <= (rst || state != WAIT_RESULT) ? '0 : wd_cnt + 1'b1;
`else
    assign timeout = 1'b0;
`endif

    assign ack  = state == WAIT_RESULT && bus.tx_result_valid && bus.tx_result_ok;
    assign nack = state == WAIT_RESULT && ((bus.tx_result_valid && !bus.tx_result_ok) || timeout);
    assign drop = nack && retry_cnt == RW'(MAX_RETRY);
    assign done = ack || drop;

    for (genvar i = 0; i < CHANNEL_NUM; i++) begin : g_vc
        logic ret_hit, dec_hit, full;
        assign ret_hit = bus.credit_ret_valid && bus.credit_ret_id == NW'(i);
        assign dec_hit = ack && gnt_id == NW'(i);
        assign full    = credit[i] == CW'(CREDIT_INIT);
        assign ovf_hit[i] = ret_hit && full && !dec_hit;
        assign elig[i] = bus.vc_req_valid[i] && credit[i] != '0;
        assign bus.credit_avail[i] = credit[i] != '0;
        // a return and an ACK decrement on the same VC cancel out
        always_ff @(posedge if_clk)
            if (rst)
                credit[i] <= CW'(CREDIT_INIT);
            else if (ret_hit && !dec_hit && !full)
                credit[i] <= credit[i] + 1'b1;
            else if (dec_hit && !ret_hit)
                credit[i] <= credit[i] - 1'b1;
    end

    // scan downward so the last hit written is the first eligible channel from rr_ptr
    always_comb begin
        pick    = rr_ptr;
        arb_idx = '0;
        for (int k = CHANNEL_NUM - 1; k >= 0; k--) begin
            arb_idx = rr_ptr + NW'(k);
            pick    = elig[arb_idx] ? arb_idx : pick;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:        state_nx = |elig ? ISSUE : IDLE;
            ISSUE:       state_nx = bus.tx_issue_ready ? WAIT_RESULT : ISSUE;
            WAIT_RESULT: state_nx = done ? IDLE : nack ? ISSUE : WAIT_RESULT;
            default:     state_nx = IDLE;
        endcase
    end

    always_ff @(posedge if_clk) begin
        if (rst) begin
            state          <= IDLE;
            gnt_id         <= '0;
            rr_ptr         <= '0;
            retry_cnt      <= '0;
            retry_err      <= 1'b0;
            credit_ovf_err <= 1'b0;
        end else begin
            state          <= state_nx;
            gnt_id         <= (state == IDLE && |elig) ? pick : gnt_id;
            rr_ptr         <= done ? (gnt_id == NW'(CHANNEL_NUM - 1) ? '0 : gnt_id + 1'b1) : rr_ptr;
            retry_cnt      <= done ? '0 : nack ? retry_cnt + 1'b1 : retry_cnt;
            retry_err      <= retry_err | drop;
            credit_ovf_err <= credit_ovf_err | (|ovf_hit);
        end
    end

    assign bus.tx_issue_valid = state == ISSUE;
    assign bus.tx_issue_id    = gnt_id;
    assign bus.busy           = state != IDLE;
    assign bus.vc_pop         = done ? CHANNEL_NUM'(1) << gnt_id : '0;
    assign bus.retry_err      = retry_err;
    assign bus.credit_ovf_err = credit_ovf_err;
endmodule

// File: tb/tb_ebi_tx_vc_scheduler.sv
// tb_ebi_tx_vc_scheduler: randomized cycle-by-cycle comparison against a transaction-level scheduler model
module tb_ebi_tx_vc_scheduler;
    localparam int N         = 4;
    localparam int CRED_MAX  = 4;
    localparam int RETRY_MAX = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ebi_tx_vc_scheduler_if bus ();

    ebi_tx_vc_scheduler dut (
        .if_clk (clk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // model: one message in flight at a time, described by who holds the grant and how far it got
    bit m_busy, m_sending, m_rerr, m_oerr;
    int m_gnt, m_ptr, m_tries;
    int m_credit [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_sending = 0; m_rerr = 0; m_oerr = 0;
        m_gnt = 0; m_ptr = 0; m_tries = 0;
        for (int i = 0; i < N; i++) m_credit[i] = CRED_MAX;
    endtask

    task automatic compare();
        bit         waiting;
        logic [3:0] exp_pop, exp_avail;
        waiting = m_busy && !m_sending;
        exp_pop = (waiting && bus.tx_result_valid && (bus.tx_result_ok || m_tries == RETRY_MAX)) ? 4'(1 << m_gnt) : 4'b0;
        for (int i = 0; i < N; i++) exp_avail[i] = m_credit[i] > 0;
        check("issue_valid", 32'(bus.tx_issue_valid), 32'(m_busy && m_sending));
        if (m_busy && m_sending) check("issue_id", 32'(bus.tx_issue_id), 32'(m_gnt));
        check("vc_pop", 32'(bus.vc_pop), 32'(exp_pop));
        check("credit_avail", 32'(bus.credit_avail), 32'(exp_avail));
        check("busy", 32'(bus.busy), 32'(m_busy));
        check("retry_err", 32'(bus.retry_err), 32'(m_rerr));
        check("credit_ovf_err", 32'(bus.credit_ovf_err), 32'(m_oerr));
    endtask

    task automatic model_step();
        bit ack, finish_msg, cancel;
        int g, id;
        if (rst) begin
            model_reset();
            return;
        end
        g   = m_gnt;
        ack = m_busy && !m_sending && bus.tx_result_valid && bus.tx_result_ok;
        if (!m_busy) begin
            for (int k = N - 1; k >= 0; k--)
                if (bus.vc_req_valid[(m_ptr + k) % N] && m_credit[(m_ptr + k) % N] > 0) begin
                    m_gnt  = (m_ptr + k) % N;
                    m_busy = 1;
                end
            m_sending = m_busy;
        end else if (m_sending) begin
            m_sending = !bus.tx_issue_ready;
        end else if (bus.tx_result_valid) begin
            finish_msg = bus.tx_result_ok || m_tries == RETRY_MAX;
            if (!bus.tx_result_ok && m_tries == RETRY_MAX) m_rerr = 1;
            if (finish_msg) begin
                m_tries = 0;
                m_ptr   = (g + 1) % N;
                m_busy  = 0;
            end else begin
                m_tries++;
                m_sending = 1;
            end
        end
        cancel = 0;
        if (bus.credit_ret_valid) begin
            id = int'(bus.credit_ret_id);
            if (ack && id == g) cancel = 1;
            else if (m_credit[id] == CRED_MAX) m_oerr = 1;
            else m_credit[id]++;
        end
        if (ack && !cancel) m_credit[g]--;
    endtask

    task automatic cycle(input int phase);
        @(negedge clk);
        rst                  = phase == 3 && $urandom_range(49) == 0;
        bus.vc_req_valid     = phase == 0 ? 4'($urandom & $urandom) : 4'($urandom);
        bus.tx_issue_ready   = $urandom_range(4) < 3;
        bus.tx_result_valid  = $urandom_range(2) == 0;
        bus.tx_result_ok     = $urandom_range(99) >= (phase == 1 ? 70 : 10);
        bus.credit_ret_valid = $urandom_range(99) < (phase == 2 ? 60 : 15);
        bus.credit_ret_id    = 2'($urandom);
        #1;
        compare();
        @(posedge clk);
        model_step();
    endtask

    initial begin
        bus.vc_req_valid     = '0;
        bus.tx_issue_ready   = 1'b0;
        bus.tx_result_valid  = 1'b0;
        bus.tx_result_ok     = 1'b0;
        bus.credit_ret_valid = 1'b0;
        bus.credit_ret_id    = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        compare();
        for (int p = 0; p < 4; p++)
            for (int c = 0; c < 800; c++)
                cycle(p);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
